// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage. It holds HI/LO and runs mult/div ops over several cycles.
// Define MD_FLUSH_EN to add a `flush` input that kills an in-flight or same-cycle operation.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  alupro_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MD_FLUSH_EN
  input  logic        flush,
`endif
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_MFHI  = 4'd8;

  localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {S_IDLE, S_RUN} state_e;

  // wr=0 marks a divide by zero, so completion leaves HI/LO alone
  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  state_e      state, state_d;
  logic [3:0]  cnt, cnt_d;
  md_res_t     pend, pend_d, calc;
  logic [31:0] hi_d, lo_d;
  logic        kill;

`ifdef MD_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  logic is_mul, is_div, is_sgn;
  assign is_mul = (alupro_op == OP_MULT) || (alupro_op == OP_MULTU);
  assign is_div = (alupro_op == OP_DIV)  || (alupro_op == OP_DIVU);
  assign is_sgn = (alupro_op == OP_MULT) || (alupro_op == OP_DIV);

  // Sign-extended operands give the correct signed product modulo 2^64
  logic [63:0] a_ext, b_ext, prod;
  assign a_ext = {{32{is_sgn & A[31]}}, A};
  assign b_ext = {{32{is_sgn & B[31]}}, B};
  assign prod  = a_ext * b_ext;

  // Divide on magnitudes, then restore signs; this also covers 0x80000000 / -1
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  assign a_neg  = is_sgn & A[31];
  assign b_neg  = is_sgn & B[31];
  assign a_mag  = a_neg ? (32'd0 - A) : A;
  assign b_mag  = b_neg ? (32'd0 - B) : B;
  assign b_zero = (B == 32'd0);
  assign b_safe = b_zero ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    calc = '0;
    if (is_div) begin
      calc.wr = ~b_zero;
      calc.hi = rem;
      calc.lo = quo;
    end else begin
      calc.wr = 1'b1;
      calc.hi = prod[63:32];
      calc.lo = prod[31:0];
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pend_d  = pend;
    hi_d    = HI;
    lo_d    = LO;
    if (state == S_IDLE) begin
      if (!kill) begin
        if (start && (is_mul || is_div)) begin
          state_d = S_RUN;
          cnt_d   = is_div ? DIV_LAST : MULT_LAST;
          pend_d  = calc;
        end else if (alupro_op == OP_MTLO) begin
          lo_d = A;
        end else if (alupro_op == OP_MTHI) begin
          hi_d = A;
        end
      end
    end else begin
      if (kill) begin
        state_d = S_IDLE;
      end else if (cnt == 4'd0) begin
        state_d = S_IDLE;
        if (pend.wr) begin
          hi_d = pend.hi;
          lo_d = pend.lo;
        end
      end else begin
        cnt_d = cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      pend  <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      pend  <= pend_d;
      HI    <= hi_d;
      LO    <= lo_d;
    end
  end

  assign busy     = (state == S_RUN);
  assign md_stall = busy | start;

  always_comb begin
    md_out = '0;
    if (alupro_op == OP_MFHI)      md_out = HI;
    else if (alupro_op == OP_MFLO) md_out = LO;
  end

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against a 64-bit arithmetic reference model.
module tb_md_unit;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alupro_op = 4'd0;
  logic [31:0] A = '0, B = '0;
`ifdef MD_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic        busy, md_stall;
  logic [31:0] HI, LO, md_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .alupro_op(alupro_op),
    .A(A), .B(B),
`ifdef MD_FLUSH_EN
    .flush(flush),
`endif
    .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO), .md_out(md_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Reference result {HI, LO}, straight from 64-bit integer arithmetic
  function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1:    return sa * sb;
      4'd2:    return ua * ub;
      4'd3:    return {32'(sa % sb), 32'(sa / sb)};
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  task automatic do_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit collide, input string tag);
    int cyc, exp_n;
    bit stall_ok;
    logic [63:0] r;
    exp_n = (op == 4'd1 || op == 4'd2) ? MULT_N : DIV_N;
    @(negedge clk);
    start = 1'b1; alupro_op = op; A = a; B = b;
    #1 chk({tag, "_stall_start"}, {31'd0, md_stall}, 32'd1);
    @(negedge clk);
    start = 1'b0; alupro_op = 4'd0; A = $urandom; B = $urandom;
    cyc = 0;
    stall_ok = 1'b1;
    while (busy && cyc < 40) begin
      cyc++;
      if (!md_stall) stall_ok = 1'b0;
      if (collide && cyc == 1) begin
        start = 1'b1; alupro_op = 4'd3; A = 32'h55; B = 32'h3;
      end else if (collide && cyc == 2) begin
        start = 1'b0; alupro_op = 4'd5; A = 32'h55;
      end else if (collide && cyc == 3) begin
        alupro_op = 4'd8;
        #1 chk({tag, "_mfhi_in_run"}, md_out, m_hi);
      end else begin
        start = 1'b0; alupro_op = 4'd0;
      end
      @(negedge clk);
    end
    start = 1'b0; alupro_op = 4'd0;
    chk({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_n));
    chk({tag, "_stall_in_run"}, {31'd0, stall_ok}, 32'd1);
    if (!((op == 4'd3 || op == 4'd4) && b == 32'd0)) begin
      r = ref_md(op, a, b);
      m_hi = r[63:32];
      m_lo = r[31:0];
    end
    chk({tag, "_hi"}, HI, m_hi);
    chk({tag, "_lo"}, LO, m_lo);
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] a, input string tag);
    @(negedge clk);
    alupro_op = op; A = a;
    @(negedge clk);
    alupro_op = 4'd0;
    if (op == 4'd5) m_lo = a; else m_hi = a;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, HI, m_hi);
    chk({tag, "_lo"}, LO, m_lo);
  endtask

  task automatic do_mf(input logic [3:0] op, input string tag);
    @(negedge clk);
    alupro_op = op;
    #1 chk(tag, md_out, (op == 4'd8) ? m_hi : ((op == 4'd7) ? m_lo : 32'd0));
    alupro_op = 4'd0;
  endtask

  // start with a code that is not mult/div must not launch anything
  task automatic do_nop(input logic [3:0] op, input string tag);
    @(negedge clk);
    start = 1'b1; alupro_op = op; A = $urandom; B = $urandom;
    #1 chk({tag, "_md_out"}, md_out, 32'd0);
    @(negedge clk);
    start = 1'b0; alupro_op = 4'd0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, HI, m_hi);
    chk({tag, "_lo"}, LO, m_lo);
  endtask

  initial begin
    logic [31:0] a, b;
    int k;

    // Reset holds everything at zero
    #12;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    do_mt(4'd6, 32'h1234_5678, "pre_mthi");
    do_mt(4'd5, 32'h9abc_def0, "pre_mtlo");
    // Asynchronous assertion mid-cycle
    @(posedge clk); #2 reset_n = 1'b0;
    m_hi = '0; m_lo = '0;
    #1;
    chk("async_rst_hi", HI, 32'd0);
    chk("async_rst_lo", LO, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hi", HI, 32'd0);
    chk("idle_lo", LO, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Directed arithmetic
    do_md(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, "multu");
    chk("multu_hi_val", HI, 32'h0000_0002);
    do_md(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
    chk("div_lo_val", LO, 32'hFFFF_FFFD);
    do_md(4'd4, 32'd7, 32'd2, 1'b0, "divu");
    chk("divu_hi_val", HI, 32'd1);
    do_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    chk("div_ovf_lo_val", LO, 32'h8000_0000);

    // Divide by zero leaves preloaded HI/LO
    do_mt(4'd6, 32'h11, "dz_mthi");
    do_mt(4'd5, 32'h22, "dz_mtlo");
    do_md(4'd3, 32'h1234, 32'd0, 1'b0, "div_by_zero");
    chk("dz_hi_val", HI, 32'h11);
    do_md(4'd4, 32'h5678, 32'd0, 1'b0, "divu_by_zero");

    // mult with start/mtlo/mfhi collisions during RUN
    do_md(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, "mult_collide");
    chk("mult_lo_val", LO, 32'hFFFF_FFFA);
    do_mf(4'd8, "mfhi");
    do_mf(4'd7, "mflo");
    chk("mflo_val", LO, 32'hFFFF_FFFA);
    do_nop(4'd0, "nop_none");
    do_nop(4'd12, "nop_bad");

    // Reset in the middle of a run abandons it
    @(negedge clk);
    start = 1'b1; alupro_op = 4'd1; A = 32'd100; B = 32'd100;
    @(negedge clk);
    start = 1'b0; alupro_op = 4'd0;
    chk("midrun_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    m_hi = '0; m_lo = '0;
    #1;
    chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
    chk("midrun_rst_hi", HI, 32'd0);
    chk("midrun_rst_lo", LO, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (MULT_N + 1) @(negedge clk);
    chk("midrun_after_busy", {31'd0, busy}, 32'd0);
    chk("midrun_after_lo", LO, 32'd0);

`ifdef MD_FLUSH_EN
    do_mt(4'd6, 32'hAAAA, "fl_mthi");
    do_mt(4'd5, 32'hBBBB, "fl_mtlo");
    @(negedge clk);
    start = 1'b1; alupro_op = 4'd1; A = 32'd3; B = 32'd4;
    @(negedge clk);
    start = 1'b0; alupro_op = 4'd0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_run_busy", {31'd0, busy}, 32'd0);
    chk("flush_run_hi", HI, m_hi);
    chk("flush_run_lo", LO, m_lo);
    @(negedge clk);
    start = 1'b1; alupro_op = 4'd3; A = 32'd9; B = 32'd2; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; alupro_op = 4'd0; flush = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    alupro_op = 4'd5; A = 32'h99; flush = 1'b1;
    @(negedge clk);
    alupro_op = 4'd0; flush = 1'b0;
    chk("flush_mtlo_lo", LO, m_lo);
`endif

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 9));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 9);
      case (k)
        0, 1, 2, 3: do_md(4'(k + 1), a, b, ($urandom_range(0, 3) == 0), "rnd_md");
        4:          do_mt(4'd5, a, "rnd_mtlo");
        5:          do_mt(4'd6, a, "rnd_mthi");
        6:          do_mf(4'd7, "rnd_mflo");
        7:          do_mf(4'd8, "rnd_mfhi");
        8:          do_nop(4'($urandom_range(9, 15)), "rnd_nop_bad");
        default:    do_nop(4'd0, "rnd_nop_none");
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
